// File: rtl/ps2_device_model_if.sv
// Byte write channel into the PS/2 device model: a valid/ready strobe carrying
// one scan-code byte plus a flag that requests a corrupted parity bit.
interface ps2_device_model_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_err;
   logic       byte_ready;

   modport master (
      output byte_valid,
      output byte_data,
      output byte_err,
      input  byte_ready
   );

   modport slave (
      input  byte_valid,
      input  byte_data,
      input  byte_err,
      output byte_ready
   );
endinterface

// File: rtl/ps2_device_model.sv
// PS/2 device-side transmitter: queues scan-code bytes and serialises each as an
// 11-bit odd-parity frame, with parity corruption, host inhibit and retry of aborted frames.
module ps2_device_model #(
   parameter int HALF_PERIOD = 2000,
   parameter int FIFO_DEPTH  = 8,
   parameter int GAP_CYCLES  = 4000
) (
   input  logic                            clk,
   input  logic                            reset_n,
   ps2_device_model_if.slave               wr,
   input  logic                            inhibit,
   output logic                            ps2_clk,
   output logic                            ps2_data,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            overflow,
   output logic [15:0]                     frames_sent
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int MAX_WAIT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
   localparam int TMR_W    = $clog2(MAX_WAIT + 1);

   localparam logic [TMR_W-1:0] HALF_LAST  = TMR_W'(HALF_PERIOD - 1);
   localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [3:0]       STOP_IDX   = 4'd10;

   typedef enum logic [1:0] {
      IDLE,
      BIT_HIGH,
      BIT_LOW,
      GAP
   } state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic [10:0]      shift_q, shift_d;
   logic [8:0]       cur_q, cur_d;
   logic [8:0]       retry_q, retry_d;
   logic             retry_valid_q, retry_valid_d;
   logic             clk_out_q, clk_out_d;
   logic             data_out_q, data_out_d;
   logic             busy_q, busy_d;
   logic [15:0]      frames_q, frames_d;
   logic             overflow_q, overflow_d;

   logic [8:0]       mem_q [FIFO_DEPTH];
   logic [8:0]       mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             full;
   logic             empty;
   logic             pop;
   logic             push;
   logic [8:0]       next_entry;

   // Frame layout, LSB first on the wire: start, data[0..7], parity, stop.
   function automatic logic [10:0] make_frame(input logic [8:0] entry);
      return {1'b1, (~^entry[7:0]) ^ entry[8], entry[7:0], 1'b0};
   endfunction

   assign full  = (count_q == FULL_COUNT);
   assign empty = (count_q == '0);

   always_comb begin
      state_d       = state_q;
      tmr_d         = tmr_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      cur_d         = cur_q;
      retry_d       = retry_q;
      retry_valid_d = retry_valid_q;
      clk_out_d     = clk_out_q;
      data_out_d    = data_out_q;
      frames_d      = frames_q;
      pop           = 1'b0;
      next_entry    = retry_valid_q ? retry_q : mem_q[rd_ptr_q];

      unique case (state_q)
         IDLE: begin
            clk_out_d  = 1'b1;
            data_out_d = 1'b1;
            tmr_d      = '0;
            if (!inhibit && (retry_valid_q || !empty)) begin
               pop           = !retry_valid_q;
               retry_valid_d = 1'b0;
               cur_d         = next_entry;
               shift_d       = make_frame(next_entry);
               data_out_d    = 1'b0;
               bit_idx_d     = '0;
               state_d       = BIT_HIGH;
            end
         end

         BIT_HIGH: begin
            if (inhibit) begin
               retry_valid_d = 1'b1;
               retry_d       = cur_q;
               clk_out_d     = 1'b1;
               data_out_d    = 1'b1;
               tmr_d         = '0;
               state_d       = GAP;
            end else if (tmr_q == HALF_LAST) begin
               tmr_d     = '0;
               clk_out_d = 1'b0;
               state_d   = BIT_LOW;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         // Once the stop bit's low phase has run its full length the frame
         // counts as delivered, even if inhibit arrives on that same cycle.
         BIT_LOW: begin
            if (tmr_q == HALF_LAST && bit_idx_q == STOP_IDX) begin
               tmr_d      = '0;
               clk_out_d  = 1'b1;
               data_out_d = 1'b1;
               frames_d   = frames_q + 16'd1;
               state_d    = GAP;
            end else if (inhibit) begin
               retry_valid_d = 1'b1;
               retry_d       = cur_q;
               clk_out_d     = 1'b1;
               data_out_d    = 1'b1;
               tmr_d         = '0;
               state_d       = GAP;
            end else if (tmr_q == HALF_LAST) begin
               tmr_d      = '0;
               clk_out_d  = 1'b1;
               shift_d    = {1'b1, shift_q[10:1]};
               data_out_d = shift_q[1];
               bit_idx_d  = bit_idx_q + 4'd1;
               state_d    = BIT_HIGH;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         GAP: begin
            clk_out_d  = 1'b1;
            data_out_d = 1'b1;
            if (tmr_q == GAP_LAST) begin
               tmr_d   = '0;
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         default: begin
            clk_out_d  = 1'b1;
            data_out_d = 1'b1;
            tmr_d      = '0;
            state_d    = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // A write into a full queue still lands when the FSM pops on the same cycle.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      push       = wr.byte_valid && (!full || pop);

      if (push) begin
         mem_d[wr_ptr_q] = {wr.byte_err, wr.byte_data};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      if (wr.byte_valid && full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         tmr_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '1;
         cur_q         <= '0;
         retry_q       <= '0;
         retry_valid_q <= 1'b0;
         clk_out_q     <= 1'b1;
         data_out_q    <= 1'b1;
         busy_q        <= 1'b0;
         frames_q      <= '0;
         overflow_q    <= 1'b0;
         mem_q         <= '{default: '0};
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         cur_q         <= cur_d;
         retry_q       <= retry_d;
         retry_valid_q <= retry_valid_d;
         clk_out_q     <= clk_out_d;
         data_out_q    <= data_out_d;
         busy_q        <= busy_d;
         frames_q      <= frames_d;
         overflow_q    <= overflow_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   assign wr.byte_ready = !full;
   assign ps2_clk       = clk_out_q;
   assign ps2_data      = data_out_q;
   assign busy          = busy_q;
   assign fifo_count    = count_q;
   assign overflow      = overflow_q;
   assign frames_sent   = frames_q;

endmodule

// File: tb/tb_ps2_device_model.sv
// Bench for ps2_device_model: a line monitor decodes frames on each ps2_clk fall and
// compares them against a scoreboard filled as bytes are written.
module tb_ps2_device_model;

   localparam int HP    = 4;
   localparam int DEPTH = 8;
   localparam int GAP_C = 10;

   logic        clk;
   logic        reset_n;
   logic        inhibit;
   logic        ps2_clk;
   logic        ps2_data;
   logic        busy;
   logic [3:0]  fifo_count;
   logic        overflow;
   logic [15:0] frames_sent;

   ps2_device_model_if bus ();

   ps2_device_model #(
      .HALF_PERIOD (HP),
      .FIFO_DEPTH  (DEPTH),
      .GAP_CYCLES  (GAP_C)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr          (bus),
      .inhibit     (inhibit),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .busy        (busy),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .frames_sent (frames_sent)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   logic [10:0] exp_q[$];
   int          starts[$];
   int          bitcnt      = 0;
   int          high_run    = 0;
   int          start_cycle = 0;
   int          frames_seen = 0;
   int          falls_total = 0;
   int          aborts      = 0;
   logic        prev_clk    = 1'b1;
   logic        prev_data   = 1'b1;
   logic [10:0] shreg       = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] d, input logic err);
      return {1'b1, (~^d) ^ err, d, 1'b0};
   endfunction

   // Writes one byte; the caller says whether it should ever appear on the wire.
   task automatic applyStimulus(input logic [7:0] d, input logic err, input bit expect_sent);
      bus.byte_data  = d;
      bus.byte_err   = err;
      bus.byte_valid = 1'b1;
      if (expect_sent) exp_q.push_back(frame_of(d, err));
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n;
      n = 0;
      while (frames_seen < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (frames_seen < target) checkOutput("timeout_frames", frames_seen, target);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Line monitor: host-side sampling on each ps2_clk fall.
   always @(negedge clk) begin
      if (!reset_n) begin
         bitcnt    = 0;
         high_run  = 0;
         prev_clk  = 1'b1;
         prev_data = 1'b1;
      end else begin
         if (prev_data && !ps2_data && ps2_clk && bitcnt == 0) begin
            start_cycle = cyc;
            starts.push_back(cyc);
         end
         if (prev_clk && !ps2_clk) begin
            if (bitcnt == 0) checkOutput("first_fall_delay", cyc - start_cycle, HP);
            shreg[bitcnt] = ps2_data;
            bitcnt++;
            falls_total++;
            if (bitcnt == 11) begin
               if (exp_q.size() == 0) checkOutput("unexpected_frame", 1, 0);
               else checkOutput("frame_bits", {21'd0, shreg}, {21'd0, exp_q.pop_front()});
               frames_seen++;
               bitcnt = 0;
            end
         end
         if (ps2_clk) high_run++;
         else high_run = 0;
         if (bitcnt > 0 && high_run > 2 * HP) begin
            bitcnt = 0;
            aborts++;
         end
         prev_clk  = ps2_clk;
         prev_data = ps2_data;
      end
   end

   initial begin
      int f0;
      int n;
      reset_n        = 1'b0;
      inhibit        = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      bus.byte_err   = 1'b0;
      wait_cycles(3);
      checkOutput("rst_ps2_clk", ps2_clk, 1);
      checkOutput("rst_ps2_data", ps2_data, 1);
      checkOutput("rst_byte_ready", bus.byte_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_fifo_count", fifo_count, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_frames_sent", frames_sent, 0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_cycles(2);

      $display("[TB] single byte 0x1C");
      f0 = falls_total;
      exp_q.push_back(11'h438);
      applyStimulus(8'h1C, 1'b0, 1'b0);
      checkOutput("count_after_write", fifo_count, 1);
      @(posedge clk);
      #1;
      checkOutput("start_bit_latency", ps2_data, 0);
      checkOutput("busy_in_frame", busy, 1);
      checkOutput("count_after_pop", fifo_count, 0);
      wait_frames(1, 400);
      wait_cycles(HP + GAP_C + 3);
      checkOutput("clk_falls_1c", falls_total - f0, 11);
      checkOutput("frames_sent_1", frames_sent, 1);
      checkOutput("idle_clk_high", ps2_clk, 1);
      checkOutput("idle_data_high", ps2_data, 1);
      checkOutput("idle_not_busy", busy, 0);

      $display("[TB] 0x1C with parity error");
      exp_q.push_back(11'h638);
      applyStimulus(8'h1C, 1'b1, 1'b0);
      wait_frames(2, 400);
      wait_cycles(HP + GAP_C + 3);
      checkOutput("frames_sent_2", frames_sent, 2);

      $display("[TB] back-to-back 0xF0, 0x1C");
      applyStimulus(8'hF0, 1'b0, 1'b1);
      applyStimulus(8'h1C, 1'b0, 1'b1);
      wait_frames(4, 600);
      wait_cycles(HP + GAP_C + 3);
      if (starts.size() >= 2)
         checkOutput("start_spacing", starts[starts.size()-1] - starts[starts.size()-2], 22 * HP + GAP_C + 1);
      else
         checkOutput("start_count", starts.size(), 2);
      checkOutput("frames_sent_4", frames_sent, 4);

      $display("[TB] overflow with drain held off");
      inhibit = 1'b1;
      wait_cycles(2);
      for (int i = 0; i < 9; i++) applyStimulus(8'h10 + 8'(i), 1'b0, i < DEPTH);
      checkOutput("full_count", fifo_count, DEPTH);
      checkOutput("full_not_ready", bus.byte_ready, 0);
      checkOutput("overflow_set", overflow, 1);
      checkOutput("held_off_idle", busy, 0);
      inhibit = 1'b0;
      wait_frames(12, 2000);
      wait_cycles(2 * (22 * HP + GAP_C + 1));
      checkOutput("frames_sent_12", frames_sent, 12);
      checkOutput("drained_count", fifo_count, 0);
      checkOutput("drained_ready", bus.byte_ready, 1);
      checkOutput("overflow_sticky", overflow, 1);

      $display("[TB] inhibit mid-frame 0x5A");
      applyStimulus(8'h5A, 1'b0, 1'b1);
      n = 0;
      while (bitcnt < 5 && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (bitcnt < 5) checkOutput("wait_fifth_fall", bitcnt, 5);
      inhibit = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_clk_high", ps2_clk, 1);
      checkOutput("abort_data_high", ps2_data, 1);
      wait_cycles(30);
      checkOutput("abort_seen", aborts, 1);
      checkOutput("abort_no_count", frames_sent, 12);
      inhibit = 1'b0;
      wait_frames(13, 400);
      wait_cycles(HP + GAP_C + 3);
      checkOutput("frames_sent_13", frames_sent, 13);

      $display("[TB] reset mid-frame");
      applyStimulus(8'h33, 1'b0, 1'b0);
      n = 0;
      while (!(bitcnt >= 3 && ps2_clk == 1'b0) && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 500) checkOutput("wait_mid_frame", bitcnt, 3);
      reset_n = 1'b0;
      #1;
      checkOutput("rst_async_clk", ps2_clk, 1);
      checkOutput("rst_async_data", ps2_data, 1);
      checkOutput("rst_mid_count", fifo_count, 0);
      checkOutput("rst_mid_frames", frames_sent, 0);
      checkOutput("rst_mid_overflow", overflow, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      wait_cycles(2);
      applyStimulus(8'h76, 1'b0, 1'b1);
      wait_frames(14, 400);
      wait_cycles(HP + GAP_C + 3);
      checkOutput("recovered_frames", frames_sent, 1);
      checkOutput("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_device_model.md
# ps2_device_model

Synthesizable, parametrised PS/2 device-side transmitter: the keyboard model for `game_console` benches and an on-board self-test source. It queues scan-code bytes in an internal FIFO and serialises each one as an 11-bit PS/2 frame on `ps2_clk`/`ps2_data`. PS/2 clock rate, FIFO depth and inter-frame gap are configurable. It supports parity-error injection and host inhibit with retransmission. It replaces idle-high PS/2 stimulus in system benches and connects directly to the console's `ps2_clk`/`ps2_data` inputs.

## Interface
- `HALF_PERIOD`, 2000: system-clock cycles per PS/2 clock half period (2000 at 100 MHz gives 25 kHz); legal range ≥2.
- `FIFO_DEPTH`, 8: byte queue depth, power of two, ≥2.
- `GAP_CYCLES`, 4000: idle cycles with both lines high after each stop bit; legal range ≥1.
- `clk`  in  1  system clock, 100 MHz nominal.
- `reset_n`  in  1  asynchronous active-low reset.
- `byte_valid`  in  1  write strobe for `byte_data`.
- `byte_data`  in  8  scan-code byte.
- `byte_err`  in  1  sampled with `byte_data`; frame is sent with inverted parity.
- `inhibit`  in  1  host inhibit (models the host holding clock low).
- `byte_ready`  out  1  FIFO not full.
- `ps2_clk`  out  1  PS/2 clock, idle high.
- `ps2_data`  out  1  PS/2 data, idle high.
- `busy`  out  1  frame in flight or gap active.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  queued bytes.
- `overflow`  out  1  sticky: a write arrived while full.
- `frames_sent`  out  16  completed frames, wraps 0xFFFF→0.

## Operation
- The FIFO stores 9 bits per entry: `{byte_err, byte_data}`.
- Write is accepted when `byte_valid && byte_ready`.
- Write while full: the byte is dropped and `overflow` is set to 1 until reset.
- Frame bit order: start 0, `data[0]`..`data[7]`, parity, stop 1.
- Parity is odd: `~^data`. When the entry's err bit is set, parity is inverted.
- FSM states:
  - IDLE: both lines high. When the FIFO is non-empty and `inhibit` is low, pop the head, load the 11-bit shift register, drive `ps2_data`=start bit, enter BIT_HIGH.
  - BIT_HIGH: `ps2_clk`=1 for `HALF_PERIOD` cycles, then enter BIT_LOW.
  - BIT_LOW: `ps2_clk`=0 for `HALF_PERIOD` cycles. Then:
    - if the bit index is 10, increment `frames_sent` and enter GAP;
    - otherwise shift, drive the next bit on `ps2_data`, and enter BIT_HIGH.
  - GAP: both lines high for `GAP_CYCLES` cycles, then enter IDLE.
- Data changes only at the BIT_LOW→BIT_HIGH transition (clock high), so the host samples on the falling edge.
- Inhibit during BIT_HIGH/BIT_LOW before the stop bit's BIT_LOW completes:
  - abort; both lines go high next cycle; enter GAP;
  - the aborted entry is retained in a retry register and resent first, before the FIFO head;
  - `frames_sent` is not incremented.
- Inhibit during GAP or IDLE only holds off the next frame start.
- Simultaneous write and pop while the FIFO is full is accepted; the count is unchanged.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values:
  - `ps2_clk`=1, `ps2_data`=1;
  - `byte_ready`=1, `busy`=0, `fifo_count`=0, `overflow`=0, `frames_sent`=0;
  - FSM in IDLE; FIFO and retry register empty.
- Reset asserted mid-frame forces both lines high asynchronously; the frame is lost.
- Latency from write to frame start: a write accepted at edge N into an empty FIFO in IDLE gives `ps2_data`=0 at edge N+1 (fall-through pop from IDLE).
- First `ps2_clk` falling edge is `HALF_PERIOD` cycles after `ps2_data` falls.
- Frame length: exactly 22×`HALF_PERIOD` cycles from start-bit drive to GAP entry.
- Frame-to-frame spacing (start to start): 22×`HALF_PERIOD`+`GAP_CYCLES`+1 cycles.
- `fifo_count` and `byte_ready` update on the edge after the write or pop.

## Test plan
- Single byte 0x1C, `HALF_PERIOD`=4 -> bits 0,0,0,1,1,1,0,0,0,0(parity),1; 11 `ps2_clk` falls; `frames_sent`=1; both lines high afterward.
- Byte 0x1C with `byte_err`=1 -> parity bit 1; all other bits as in the previous case.
- Back-to-back 0xF0 then 0x1C, `GAP_CYCLES`=10 -> two frames whose start bits are 22×4+11=99 cycles apart.
- Write 9 bytes into `FIFO_DEPTH`=8 with no drain (inhibit high) -> `fifo_count`=8, `byte_ready`=0, `overflow`=1; the 9th byte is never transmitted.
- Raise `inhibit` after the 5th clock fall of byte 0x5A -> lines high next cycle; after `inhibit` drops, a complete 0x5A frame is sent; `frames_sent`=1.
- Assert `reset_n`=0 mid-frame -> `ps2_clk`/`ps2_data` go high within the same cycle; `fifo_count`=0; `frames_sent`=0.
